// File: rtl/mul16_shift_add.sv
// mul16_shift_add: 16-cycle shift-and-add multiplier, low 16 bits of a*b.
// Define MUL16_EARLY_EXIT_EN to finish as soon as the remaining multiplier bits are all zero.
module mul16_ripple_add (
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    output logic [15:0] sum_o
);
    logic [15:0] c;
    assign c[0] = 1'b0;
    for (genvar i = 0; i < 16; i++) begin : g_fa
        assign sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
        // carry out of bit 15 is dropped, so the chain stops one short
        if (i < 15) begin : g_c
            assign c[i+1] = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
        end
    end
endmodule

module mul16_shift_add (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] product,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t      state_q, state_d;
    logic [15:0] acc_q, acc_d, mcand_q, mcand_d, mplier_q, mplier_d, res_q, res_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] sum, acc_step;
    logic        last;

    mul16_ripple_add u_add (.a_i(acc_q), .b_i(mcand_q), .sum_o(sum));

    assign acc_step = mplier_q[0] ? sum : acc_q;
`ifdef MUL16_EARLY_EXIT_EN
    assign last = (mplier_q[15:1] == 15'd0);
`else
    assign last = (cnt_q == 4'd15);
`endif

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        res_d    = res_q;
        case (state_q)
            IDLE: if (in_valid) begin
                acc_d    = 16'd0;
                mcand_d  = a;
                mplier_d = b;
                cnt_d    = 4'd0;
                state_d  = RUN;
            end
            RUN: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 4'd1;
                if (last) begin
                    res_d   = acc_step;
                    state_d = DONE;
                end
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            acc_q    <= 16'd0;
            mcand_q  <= 16'd0;
            mplier_q <= 16'd0;
            cnt_q    <= 4'd0;
            res_q    <= 16'd0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            res_q    <= res_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign product   = res_q;
endmodule

// File: tb/tb_mul16_shift_add.sv
// tb_mul16_shift_add: vector table, random and corner sequences against an arithmetic model.
module tb_mul16_shift_add;
    logic        clk = 1'b0, reset_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
    logic [15:0] a = 16'd0, b = 16'd0;
    logic        in_ready, out_valid, busy;
    logic [15:0] product;
    int          n_cmp = 0, n_err = 0, cyc = 0;

    typedef struct {logic [15:0] a; logic [15:0] b; logic [15:0] p;} vec_t;
    vec_t vecs[8];

    mul16_shift_add dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .product(product), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] model(input logic [15:0] x, input logic [15:0] y);
        int unsigned full;
        full = int'(x) * int'(y);
        return full[15:0];
    endfunction

    function automatic int lat_exp(input logic [15:0] y);
`ifdef MUL16_EARLY_EXIT_EN
        int hi = 0;
        for (int i = 0; i < 16; i++) if (y[i]) hi = i;
        return hi + 1;
`else
        return 16;
`endif
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk); @(negedge clk); n++;
        end
    endtask

    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_, input logic [15:0] exp_p);
        int n;
        @(negedge clk);
        a = ta; b = tb_; in_valid = 1'b1;
        chk("in_ready_idle", in_ready, 1);
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        chk("busy_run", busy, 1);
        wait_out(n);
        chk("latency", n, lat_exp(tb_));
        chk("product", product, exp_p);
        @(posedge clk); @(negedge clk);
        chk("out_valid_drop", out_valid, 0);
        chk("busy_after", busy, 0);
    endtask

    initial begin
        int n, t_prev, t_now;
        logic [15:0] ra, rb, held;
        logic [15:0] pa[3], pb[3], pp[3];
        vecs[0] = '{16'd3, 16'd5, 16'h000F};
        vecs[1] = '{16'd300, 16'd300, 16'h5F90};
        vecs[2] = '{16'hFFFF, 16'hFFFF, 16'h0001};
        vecs[3] = '{16'h1234, 16'h0010, 16'h2340};
        vecs[4] = '{16'h0000, 16'h1234, 16'h0000};
        vecs[5] = '{16'h1234, 16'h0000, 16'h0000};
        vecs[6] = '{16'h1234, 16'h0001, 16'h1234};
        vecs[7] = '{16'h1234, 16'h0008, 16'h91A0};

        #12;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_product", product, 0);
        @(negedge clk); reset_n = 1'b1;

        foreach (vecs[i]) run_op(vecs[i].a, vecs[i].b, vecs[i].p);

        for (int i = 0; i < 20; i++) begin
            ra = 16'($urandom); rb = 16'($urandom);
            if (i == 0) rb = 16'h8000;
            run_op(ra, rb, model(ra, rb));
        end

        // consumer stalls while in_valid toggles; DONE must hold and ignore operands
        out_ready = 1'b0;
        @(negedge clk); a = 16'd5; b = 16'd6; in_valid = 1'b1;
        @(posedge clk); @(negedge clk); in_valid = 1'b0;
        wait_out(n);
        chk("stall_product", product, 16'd30);
        a = 16'd7; b = 16'd7;
        for (int i = 0; i < 10; i++) begin
            in_valid = ~in_valid;
            @(posedge clk); @(negedge clk);
            chk("stall_out_valid", out_valid, 1);
            chk("stall_hold", product, 16'd30);
            chk("stall_in_ready", in_ready, 0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("stall_release", out_valid, 0);
        chk("idle_hold", product, 16'd30);
        run_op(16'd7, 16'd7, 16'd49);

        // async reset in the middle of RUN
        @(negedge clk); a = 16'hFFFF; b = 16'hFFFF; in_valid = 1'b1;
        @(posedge clk); @(negedge clk); in_valid = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk); reset_n = 1'b0; #1;
        chk("abort_busy", busy, 0);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_in_ready", in_ready, 1);
        chk("abort_product", product, 0);
        repeat (2) begin
            @(posedge clk); @(negedge clk);
            chk("abort_no_valid", out_valid, 0);
        end
        reset_n = 1'b1;
        run_op(16'd2, 16'd9, 16'h0012);

        // back-to-back with in_valid held high
        pa = '{16'd1, 16'd0, 16'h00FF};
        pb = '{16'd1, 16'h8000, 16'h0101};
        pp = '{16'h0001, 16'h0000, 16'hFFFF};
        t_prev = 0;
        @(negedge clk);
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            a = pa[k]; b = pb[k];
            n = 0;
            while (!in_ready && n < 100) begin
                @(negedge clk); n++;
            end
            chk("b2b_ready_wait", (n < 100), 1);
            @(posedge clk); @(negedge clk);
            t_now = cyc;
            if (k > 0) chk("b2b_spacing", t_now - t_prev, lat_exp(pb[k-1]) + 2);
            t_prev = t_now;
            a = 16'hA5A5; b = 16'h5A5A;
            wait_out(n);
            chk("b2b_latency", n, lat_exp(pb[k]));
            chk("b2b_product", product, pp[k]);
        end
        in_valid = 1'b0;
        held = product;
        @(posedge clk); @(negedge clk);
        chk("b2b_drop", out_valid, 0);
        chk("b2b_idle_hold", product, held);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
